// File: rtl/df_channel_profiler_if.sv
// Channel tap and query/response bundle for the dataflow channel profiler.
// The master side drives the taps and queries; the profiler is the slave.
interface df_channel_profiler_if #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0] ch_wr_en;
    logic [NUM_CH-1:0] ch_rd_en;
    logic [NUM_CH-1:0] ch_wr_block;
    logic [NUM_CH-1:0] ch_rd_block;
    logic              query_valid;
    logic [4:0]        query_ch;
    logic [2:0]        query_field;
    logic              resp_valid;
    logic [CNT_W-1:0]  resp_data;

    modport master (
        output ch_wr_en, ch_rd_en, ch_wr_block, ch_rd_block,
        output query_valid, query_ch, query_field,
        input  resp_valid, resp_data
    );

    modport slave (
        input  ch_wr_en, ch_rd_en, ch_wr_block, ch_rd_block,
        input  query_valid, query_ch, query_field,
        output resp_valid, resp_data
    );
endinterface

// File: rtl/df_channel_profiler.sv
// Dataflow channel profiler: per-channel occupancy, blocking and transfer
// statistics plus global stall detection, read back through a registered query port.
module df_channel_profiler #(
    parameter int NUM_CH    = 6,
    parameter int DEPTH_W   = 8,
    parameter int CNT_W     = 32,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 finish,
    input  logic [TIMEOUT_W-1:0] stall_timeout,
    df_channel_profiler_if.slave bus,
    output logic [1:0]           state,
    output logic                 deadlock,
    output logic [4:0]           deadlock_ch,
    output logic                 err_any
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t               st, st_nxt;
    logic                 clear, run, declare;
    logic                 progress, blocked, stalled;
    logic [4:0]           low_ch;
    logic [TIMEOUT_W-1:0] stall_cnt, stall_nxt;

    logic [DEPTH_W-1:0]   occ        [NUM_CH];
    logic [DEPTH_W-1:0]   occ_nxt    [NUM_CH];
    logic [DEPTH_W-1:0]   max_occ    [NUM_CH];
    logic [CNT_W-1:0]     rd_blk_cnt [NUM_CH];
    logic [CNT_W-1:0]     wr_blk_cnt [NUM_CH];
    logic [CNT_W-1:0]     wr_cnt     [NUM_CH];
    logic [CNT_W-1:0]     rd_cnt     [NUM_CH];
    logic [CNT_W-1:0]     run_cycles;
    logic [NUM_CH-1:0]    udf, ovf, udf_set, ovf_set;

    logic [IDX_W-1:0]     qi;
    logic [CNT_W-1:0]     qdata;
    logic                 resp_vld_p1;
    logic [CNT_W-1:0]     resp_data_p1;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [TIMEOUT_W-1:0] sat_tmo(input logic [TIMEOUT_W-1:0] v);
        return (&v) ? v : v + TIMEOUT_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) st <= IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        clear  = 1'b0;
        case (st)
            IDLE: if (start) begin st_nxt = RUN; clear = 1'b1; end
            RUN:  if (finish || declare) st_nxt = DONE;
            DONE: if (start) begin st_nxt = RUN; clear = 1'b1; end
            default: st_nxt = IDLE;
        endcase
    end

    assign run   = (st == RUN);
    assign state = st;

    // A stall is a cycle with some channel blocked and no channel moving data.
    assign progress  = |(bus.ch_wr_en | bus.ch_rd_en);
    assign blocked   = |(bus.ch_wr_block | bus.ch_rd_block);
    assign stalled   = blocked && !progress;
    assign stall_nxt = stalled ? sat_tmo(stall_cnt) : '0;
    assign declare   = run && stalled && (stall_timeout != '0) && (stall_nxt == stall_timeout);

    always_comb begin
        low_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (bus.ch_wr_block[i] || bus.ch_rd_block[i]) low_ch = 5'(i);
    end

    always_comb begin
        udf_set = '0;
        ovf_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            occ_nxt[i] = occ[i];
            if (bus.ch_wr_en[i] && !bus.ch_rd_en[i]) begin
                if (&occ[i]) ovf_set[i] = 1'b1;
                else         occ_nxt[i] = occ[i] + DEPTH_W'(1);
            end else if (!bus.ch_wr_en[i] && bus.ch_rd_en[i]) begin
                if (occ[i] == '0) udf_set[i] = 1'b1;
                else              occ_nxt[i] = occ[i] - DEPTH_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                occ[i]        <= '0;
                max_occ[i]    <= '0;
                rd_blk_cnt[i] <= '0;
                wr_blk_cnt[i] <= '0;
                wr_cnt[i]     <= '0;
                rd_cnt[i]     <= '0;
            end
            udf         <= '0;
            ovf         <= '0;
            run_cycles  <= '0;
            stall_cnt   <= '0;
            deadlock    <= 1'b0;
            deadlock_ch <= '0;
            err_any     <= 1'b0;
        end else begin
            err_any <= |(udf | ovf);
            if (run) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    occ[i] <= occ_nxt[i];
                    if (occ_nxt[i] > max_occ[i]) max_occ[i] <= occ_nxt[i];
                    if (bus.ch_rd_block[i]) rd_blk_cnt[i] <= sat_cnt(rd_blk_cnt[i]);
                    if (bus.ch_wr_block[i]) wr_blk_cnt[i] <= sat_cnt(wr_blk_cnt[i]);
                    if (bus.ch_wr_en[i])    wr_cnt[i]     <= sat_cnt(wr_cnt[i]);
                    if (bus.ch_rd_en[i])    rd_cnt[i]     <= sat_cnt(rd_cnt[i]);
                end
                udf        <= udf | udf_set;
                ovf        <= ovf | ovf_set;
                run_cycles <= sat_cnt(run_cycles);
                stall_cnt  <= stall_nxt;
                if (declare) begin
                    deadlock    <= 1'b1;
                    deadlock_ch <= low_ch;
                end
            end
        end
    end

    always_comb begin
        qi    = bus.query_ch[IDX_W-1:0];
        qdata = '0;
        if (int'(bus.query_ch) < NUM_CH) begin
            case (bus.query_field)
                3'd0: qdata = CNT_W'(occ[qi]);
                3'd1: qdata = CNT_W'(max_occ[qi]);
                3'd2: qdata = rd_blk_cnt[qi];
                3'd3: qdata = wr_blk_cnt[qi];
                3'd4: qdata = wr_cnt[qi];
                3'd5: qdata = rd_cnt[qi];
                3'd6: qdata = CNT_W'({deadlock, ovf[qi], udf[qi]});
                3'd7: qdata = run_cycles;
            endcase
        end
    end

    // Response stage: answers reflect the statistics before this edge's update.
    always_ff @(posedge clock) begin
        if (!reset) begin
            resp_vld_p1  <= 1'b0;
            resp_data_p1 <= '0;
        end else begin
            resp_vld_p1 <= bus.query_valid;
            if (bus.query_valid) resp_data_p1 <= qdata;
        end
    end

    assign bus.resp_valid = resp_vld_p1;
    assign bus.resp_data  = resp_data_p1;
endmodule
